// File: rtl/o_ddr_ser_pkg.sv
// Shared constants and helpers for the O_DDR output gearbox.
// Latency: none (package only).
// Backpressure: none (package only).
package o_ddr_ser_pkg;

    // Pattern driven on Q when no payload is present.
    localparam logic [1:0] IDLE_PAT_DEFAULT = 2'b00;

    // Width of the saturating underflow event counter.
    localparam int UF_CNT_W = 16;

    // Bits needed to hold a pair count in the range 0..width/2.
    function automatic int cnt_width(input int width);
        return $clog2(width / 2 + 1);
    endfunction

endpackage

// File: rtl/o_ddr_ser_hold.sv
// One-entry holding register between the parallel producer and the shift register.
// Latency: word visible on hold_dat one edge after the accept.
// Backpressure: in_rdy low while full or in reset; the entry frees on a load strobe.
module o_ddr_ser_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             load,
    output logic [WIDTH-1:0] hold_dat,
    output logic             full
);

    // Ready only when out of reset and the entry is empty.
    assign in_rdy = rst_n && !full;

    // Capture on handshake, release when the shift register takes the word.
    // Accept and load cannot coincide: in_rdy is low whenever full is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_dat <= '0;
            full     <= 1'b0;
        end else if (in_vld && in_rdy) begin
            hold_dat <= in_dat;
            full     <= 1'b1;
        end else if (load) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/o_ddr_serializer.sv
// Parallel-to-pair gearbox feeding an O_DDR D input; Q[0] goes out while C is high, Q[1] while C is low.
// Latency: word accepted at edge k shows its first pair after edge k+2 (empty pipe); WIDTH/2 pairs per word.
// Backpressure: DATA_READY = R && !hold_full; optional UNDERFLOW_CNT/CNT_CLR via O_DDR_SERIALIZER_UNDERFLOW_CNT_EN.
module o_ddr_serializer
    import o_ddr_ser_pkg::*;
#(
    parameter int         WIDTH        = 8,
    parameter logic [1:0] IDLE_PATTERN = IDLE_PAT_DEFAULT
) (
    input  logic                C,
    input  logic                R,
`ifdef O_DDR_SERIALIZER_UNDERFLOW_CNT_EN
    input  logic                CNT_CLR,
    output logic [UF_CNT_W-1:0] UNDERFLOW_CNT,
`endif
    input  logic [WIDTH-1:0]    DATA_IN,
    input  logic                DATA_VALID,
    output logic                DATA_READY,
    output logic [1:0]          Q,
    output logic                Q_VALID,
    output logic                UNDERFLOW
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] PAIRS    = CNT_W'(WIDTH / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hold_dat;
    logic [CNT_W-1:0] cnt;
    logic             hold_full;
    logic             load;
    logic             uf_nxt;

    // Refill when the current word is on its last pair (or idle) so words run back to back.
    assign load = hold_full && (cnt <= CNT_ONE);

    // Stream runs dry: a pair was on Q and nothing is left to emit.
    assign uf_nxt = Q_VALID && (cnt == '0);

    o_ddr_ser_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk      (C),
        .rst_n    (R),
        .in_dat   (DATA_IN),
        .in_vld   (DATA_VALID),
        .in_rdy   (DATA_READY),
        .load     (load),
        .hold_dat (hold_dat),
        .full     (hold_full)
    );

    // Shift register, pair counter and registered outputs; a reset drops any partial word silently.
    always_ff @(posedge C) begin
        if (!R) begin
            sr        <= '0;
            cnt       <= '0;
            Q         <= IDLE_PATTERN;
            Q_VALID   <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (cnt != '0) begin
                Q       <= sr[1:0];
                Q_VALID <= 1'b1;
            end else begin
                Q       <= IDLE_PATTERN;
                Q_VALID <= 1'b0;
            end
            UNDERFLOW <= uf_nxt;
            if (load) begin
                sr  <= hold_dat;
                cnt <= PAIRS;
            end else if (cnt != '0) begin
                sr  <= sr >> 2;
                cnt <= cnt - CNT_ONE;
            end
        end
    end

`ifdef O_DDR_SERIALIZER_UNDERFLOW_CNT_EN
    // Saturating count of underflow events; clear takes priority over a same-cycle event.
    always_ff @(posedge C) begin
        if (!R) begin
            UNDERFLOW_CNT <= '0;
        end else if (CNT_CLR) begin
            UNDERFLOW_CNT <= '0;
        end else if (uf_nxt && (UNDERFLOW_CNT != {UF_CNT_W{1'b1}})) begin
            UNDERFLOW_CNT <= UNDERFLOW_CNT + UF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_o_ddr_serializer.sv
// Bench for the O_DDR gearbox: WIDTH=8 instance against a timeline model, WIDTH=4 instance directed.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_o_ddr_serializer;

    localparam int W    = 8;
    localparam int MAXC = 3000;

    logic       C = 1'b0;
    always #5 C = ~C;

    // WIDTH=8 instance signals
    logic       R;
    logic [7:0] DATA_IN;
    logic       DATA_VALID;
    logic       DATA_READY;
    logic [1:0] Q;
    logic       Q_VALID;
    logic       UNDERFLOW;

    // WIDTH=4 instance signals
    logic       r4;
    logic [3:0] data_in4;
    logic       data_valid4;
    logic       data_ready4;
    logic [1:0] q4;
    logic       q_valid4;
    logic       underflow4;

`ifdef O_DDR_SERIALIZER_UNDERFLOW_CNT_EN
    logic        CNT_CLR;
    logic [15:0] UNDERFLOW_CNT;
    logic        cnt_clr4;
    logic [15:0] underflow_cnt4;
`endif

    o_ddr_serializer #(.WIDTH(8), .IDLE_PATTERN(2'b00)) dut (
        .C          (C),
        .R          (R),
`ifdef O_DDR_SERIALIZER_UNDERFLOW_CNT_EN
        .CNT_CLR       (CNT_CLR),
        .UNDERFLOW_CNT (UNDERFLOW_CNT),
`endif
        .DATA_IN    (DATA_IN),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .Q          (Q),
        .Q_VALID    (Q_VALID),
        .UNDERFLOW  (UNDERFLOW)
    );

    o_ddr_serializer #(.WIDTH(4), .IDLE_PATTERN(2'b00)) dut4 (
        .C          (C),
        .R          (r4),
`ifdef O_DDR_SERIALIZER_UNDERFLOW_CNT_EN
        .CNT_CLR       (cnt_clr4),
        .UNDERFLOW_CNT (underflow_cnt4),
`endif
        .DATA_IN    (data_in4),
        .DATA_VALID (data_valid4),
        .DATA_READY (data_ready4),
        .Q          (q4),
        .Q_VALID    (q_valid4),
        .UNDERFLOW  (underflow4)
    );

    int errs   = 0;
    int checks = 0;

    // Timeline model: per-edge expected pair, plus the edge after which the holding slot frees
    // and the edge of the last scheduled pair.
    bit         sv [0:MAXC+64];
    logic [1:0] sq [0:MAXC+64];
    int         cyc       = 0;
    int         hold_free = 0;
    int         last_end  = 0;
    bit         prev_v    = 0;
    int         uf_model  = 0;
    bit         rdy_seen;
    bit         acc4;

    // WIDTH=4 observation
    logic [1:0] q4_seen[$];
    int         q4_first = -1;
    int         q4_last  = -1;
    int         uf4      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one edge: check ready, update the model from the inputs about to be sampled, then check outputs.
    task automatic step();
        int e;
        int s;
        bit rst_e;
        bit exp_v;
        bit exp_u;
        #1;
        rdy_seen = DATA_READY;
        acc4     = data_valid4 && data_ready4;
        chk("ready", DATA_READY, R && (cyc >= hold_free));
        e     = cyc + 1;
        rst_e = !R;
        if (e > MAXC) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", e, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        if (rst_e) begin
            for (int k = e; k < e + 2 * W + 8; k++) sv[k] = 1'b0;
            hold_free = e;
            last_end  = e;
            uf_model  = 0;
        end else if (DATA_VALID && (cyc >= hold_free)) begin
            s = (e + 2 > last_end + 1) ? e + 2 : last_end + 1;
            for (int p = 0; p < W / 2; p++) begin
                sv[s + p] = 1'b1;
                sq[s + p] = DATA_IN[2 * p +: 2];
            end
            last_end  = s + W / 2 - 1;
            hold_free = s - 1;
        end
        @(posedge C);
        cyc = e;
        #1;
        exp_v = sv[e];
        exp_u = !rst_e && prev_v && !exp_v;
        prev_v = exp_v;
        if (exp_u) uf_model++;
        chk("q_valid", Q_VALID, exp_v);
        chk("q", Q, exp_v ? sq[e] : 2'b00);
        chk("underflow", UNDERFLOW, exp_u);
        if (q_valid4) begin
            q4_seen.push_back(q4);
            if (q4_first < 0) q4_first = cyc;
            q4_last = cyc;
        end
        if (underflow4) uf4++;
    endtask

    initial begin
        int bp_rdy;
        int npairs;
        int idx;
        logic [3:0] w4 [2];
        logic [1:0] exp4 [4];
        w4   = '{4'h6, 4'h9};
        exp4 = '{2'b10, 2'b01, 2'b01, 2'b10};

        R = 1'b0; DATA_VALID = 1'b1; DATA_IN = 8'hA5;
        r4 = 1'b0; data_valid4 = 1'b0; data_in4 = 4'h0;
`ifdef O_DDR_SERIALIZER_UNDERFLOW_CNT_EN
        CNT_CLR = 1'b0; cnt_clr4 = 1'b0;
`endif
        // Reset held for three edges with DATA_VALID high
        for (int i = 0; i < 3; i++) begin
            DATA_IN = 8'(i * 37);
            step();
        end
        R = 1'b1; r4 = 1'b1; DATA_VALID = 1'b0;
        step();
        chk("ready_after_reset", DATA_READY, 1'b1);

        // Single word
        DATA_VALID = 1'b1; DATA_IN = 8'hB4;
        step();
        DATA_VALID = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Back-to-back words with DATA_VALID held
        idx = 0;
        for (int i = 0; i < 30 && idx < 2; i++) begin
            DATA_VALID = 1'b1;
            DATA_IN    = (idx == 0) ? 8'h1B : 8'hE4;
            step();
            if (rdy_seen) idx++;
        end
        chk("b2b_accepts", idx, 2);
        DATA_VALID = 1'b0;
        for (int i = 0; i < 14; i++) step();

        // Backpressure: data changes every cycle regardless of ready
        bp_rdy = 0;
        for (int i = 0; i < 40; i++) begin
            DATA_VALID = 1'b1;
            DATA_IN    = 8'(8'h40 + i);
            step();
            if (i >= 8 && i < 28 && rdy_seen) bp_rdy++;
        end
        chk("bp_ready_duty", bp_rdy, 5);
        DATA_VALID = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            R          = ($urandom_range(0, 59) != 0);
            DATA_VALID = $urandom_range(0, 2) != 0;
            DATA_IN    = 8'($urandom);
            step();
        end
        R = 1'b1; DATA_VALID = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Mid-word reset after the second pair of 8'hFF
        DATA_VALID = 1'b1; DATA_IN = 8'hFF;
        step();
        DATA_VALID = 1'b0;
        npairs = 0;
        for (int i = 0; i < 10 && npairs < 2; i++) begin
            step();
            if (Q_VALID) npairs++;
        end
        chk("midreset_pairs_seen", npairs, 2);
        R = 1'b0;
        step();
        R = 1'b1;
        step();
        chk("midreset_no_uf", UNDERFLOW, 1'b0);
        DATA_VALID = 1'b1; DATA_IN = 8'h0F;
        step();
        DATA_VALID = 1'b0;
        for (int i = 0; i < 10; i++) step();
`ifdef O_DDR_SERIALIZER_UNDERFLOW_CNT_EN
        chk("uf_cnt8", UNDERFLOW_CNT, uf_model);
`endif

        // WIDTH=4, two continuous words
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            data_valid4 = (idx < 2);
            data_in4    = w4[(idx < 2) ? idx : 0];
            step();
            if (acc4) idx++;
        end
        data_valid4 = 1'b0;
        chk("w4_accepts", idx, 2);
        chk("w4_pairs", q4_seen.size(), 4);
        chk("w4_gapfree_span", q4_last - q4_first, 3);
        for (int p = 0; p < 4; p++) begin
            if (p < q4_seen.size()) chk($sformatf("w4_pair%0d", p), q4_seen[p], exp4[p]);
        end
        chk("w4_uf_pulses", uf4, 1);
`ifdef O_DDR_SERIALIZER_UNDERFLOW_CNT_EN
        chk("w4_uf_cnt", underflow_cnt4, 1);
        cnt_clr4 = 1'b1;
        step();
        cnt_clr4 = 1'b0;
        step();
        chk("w4_uf_cnt_clr", underflow_cnt4, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
